// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and packing constants for the instruction memory loader
package imem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LOAD = 2'd2
    } state_t;

    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_byte_word_packer.sv
// rtl/imem_loader_byte_word_packer.sv - packs accepted stream bytes into little-endian 32-bit words
module byte_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        take,
    input  logic [7:0]  data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  index;
    logic [23:0] assembly;

    // The last byte of a word is never stored: it goes straight into the written word.
    assign word_valid = take && (index == 2'(BYTES_PER_WORD - 1));
    assign word       = {data, assembly};

    // Byte index counter and assembly register; clear drops any partial word at load start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index    <= '0;
            assembly <= '0;
        end else if (clear) begin
            index    <= '0;
            assembly <= '0;
        end else if (take) begin
            case (index)
                2'd0:    assembly[7:0]   <= data;
                2'd1:    assembly[15:8]  <= data;
                2'd2:    assembly[23:16] <= data;
                default: assembly        <= assembly;
            endcase
            index <= index + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader and asynchronous read port of the instruction RAM
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W:0]   word_count_i,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    input  logic [31:0]       pc_i,
    output logic [31:0]       instr_o,
    output logic              cpu_rst_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W:0]   words_loaded_o
);

    localparam int              DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    logic [ADDR_W:0]   target;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       mem [DEPTH];

    logic              take;
    logic              start_load;
    logic              word_valid;
    logic [31:0]       word;
    logic              unused_pc;

    assign take       = byte_valid_i && byte_ready_o;
    assign start_load = start_i && (state != LOAD) && (word_count_i != '0);

    byte_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_load),
        .take       (take),
        .data       (byte_i),
        .word_valid (word_valid),
        .word       (word)
    );

    // Load sequencing with registered handshake, core-reset and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            byte_ready_o   <= 1'b0;
            cpu_rst_o      <= 1'b1;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            words_loaded_o <= '0;
            target         <= '0;
            wr_addr        <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE, RUN: begin
                    if (start_i) begin
                        if (word_count_i == '0) begin
                            state        <= RUN;
                            cpu_rst_o    <= 1'b0;
                            byte_ready_o <= 1'b0;
                            busy_o       <= 1'b0;
                            done_o       <= 1'b1;
                        end else begin
                            state          <= LOAD;
                            target         <= (word_count_i > DEPTH_W) ? DEPTH_W : word_count_i;
                            wr_addr        <= '0;
                            words_loaded_o <= '0;
                            byte_ready_o   <= 1'b1;
                            busy_o         <= 1'b1;
                            cpu_rst_o      <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    // start_i is deliberately ignored here so the original target stands.
                    if (word_valid) begin
                        wr_addr        <= wr_addr + 1'b1;
                        words_loaded_o <= words_loaded_o + 1'b1;
                        if (words_loaded_o + 1'b1 == target) begin
                            state        <= RUN;
                            byte_ready_o <= 1'b0;
                            busy_o       <= 1'b0;
                            cpu_rst_o    <= 1'b0;
                            done_o       <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Instruction RAM write; contents are intentionally left untouched by rst.
    always_ff @(posedge clk) begin
        if (word_valid) begin
            mem[wr_addr] <= word;
        end
    end

    assign instr_o   = mem[pc_i[ADDR_W+1:2]];
    assign unused_pc = ^{pc_i[31:ADDR_W+2], pc_i[1:0]};

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [6:0]  word_count_i;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        byte_ready_o;
    logic [31:0] pc_i;
    logic [31:0] instr_o;
    logic        cpu_rst_o;
    logic        busy_o;
    logic        done_o;
    logic [6:0]  words_loaded_o;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    logic [7:0] prog [8] = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};

    imem_loader #(.ADDR_W(6)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .word_count_i   (word_count_i),
        .byte_i         (byte_i),
        .byte_valid_i   (byte_valid_i),
        .byte_ready_o   (byte_ready_o),
        .pc_i           (pc_i),
        .instr_o        (instr_o),
        .cpu_rst_o      (cpu_rst_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .words_loaded_o (words_loaded_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done_o === 1'b1) done_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_start(input logic [6:0] c);
        start_i      = 1'b1;
        word_count_i = c;
        @(negedge clk);
        start_i      = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok);
        ok           = 1'b0;
        byte_i       = b;
        byte_valid_i = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (byte_ready_o === 1'b1) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        byte_valid_i = 1'b0;
    endtask

    task automatic peek(input logic [31:0] pc, output logic [31:0] v);
        pc_i = pc;
        #1;
        v = instr_o;
    endtask

    task automatic test_reset;
        rst = 1'b1; start_i = 1'b0; word_count_i = '0; byte_i = '0; byte_valid_i = 1'b0; pc_i = '0;
        @(negedge clk);
        checks++; if (byte_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b, expected 0", byte_ready_o); end
        checks++; if (cpu_rst_o !== 1'b1) begin errors++; $display("FAIL reset_cpu_rst: got %b, expected 1", cpu_rst_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, expected 0", done_o); end
        checks++; if (words_loaded_o !== 7'd0) begin errors++; $display("FAIL reset_words: got %0d, expected 0", words_loaded_o); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        bit ok, all_ok;
        logic [31:0] v;
        all_ok = 1'b1;
        do_start(7'd2);
        checks++; if (busy_o !== 1'b1 || byte_ready_o !== 1'b1 || cpu_rst_o !== 1'b1) begin errors++; $display("FAIL b2b_load_flags: got busy=%b ready=%b cpu_rst=%b, expected 1 1 1", busy_o, byte_ready_o, cpu_rst_o); end
        for (int i = 0; i < 8; i++) begin
            send_byte(prog[i], ok);
            all_ok &= ok;
        end
        checks++; if (!all_ok) begin errors++; $display("FAIL b2b_accept: got timeout, expected all bytes accepted"); end
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b, expected 1", done_o); end
        checks++; if (cpu_rst_o !== 1'b0) begin errors++; $display("FAIL b2b_cpu_rst: got %b, expected 0", cpu_rst_o); end
        checks++; if (byte_ready_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL b2b_run_flags: got ready=%b busy=%b, expected 0 0", byte_ready_o, busy_o); end
        checks++; if (words_loaded_o !== 7'd2) begin errors++; $display("FAIL b2b_words: got %0d, expected 2", words_loaded_o); end
        @(negedge clk);
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL b2b_done_pulse: got %b, expected 0", done_o); end
        peek(32'h0, v);
        checks++; if (v !== 32'h00100513) begin errors++; $display("FAIL b2b_mem0: got %h, expected 00100513", v); end
        peek(32'h4, v);
        checks++; if (v !== 32'h00200593) begin errors++; $display("FAIL b2b_mem1: got %h, expected 00200593", v); end
        peek(32'h104, v);
        checks++; if (v !== 32'h00200593) begin errors++; $display("FAIL b2b_wrap: got %h, expected 00200593", v); end
    endtask

    task automatic test_stall;
        bit ok, all_ok, rdy_ok;
        logic [31:0] v;
        all_ok = 1'b1; rdy_ok = 1'b1;
        do_start(7'd2);
        checks++; if (cpu_rst_o !== 1'b1 || words_loaded_o !== 7'd0) begin errors++; $display("FAIL stall_start: got cpu_rst=%b words=%0d, expected 1 0", cpu_rst_o, words_loaded_o); end
        for (int i = 0; i < 8; i++) begin
            send_byte(prog[i], ok);
            all_ok &= ok;
            if (i < 7) begin
                for (int g = 0; g < 3; g++) begin
                    if (byte_ready_o !== 1'b1) rdy_ok = 1'b0;
                    @(negedge clk);
                end
            end
        end
        checks++; if (!all_ok) begin errors++; $display("FAIL stall_accept: got timeout, expected all bytes accepted"); end
        checks++; if (!rdy_ok) begin errors++; $display("FAIL stall_ready: got ready low in LOAD, expected 1"); end
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL stall_done: got %b, expected 1", done_o); end
        checks++; if (words_loaded_o !== 7'd2) begin errors++; $display("FAIL stall_words: got %0d, expected 2", words_loaded_o); end
        peek(32'h0, v);
        checks++; if (v !== 32'h00100513) begin errors++; $display("FAIL stall_mem0: got %h, expected 00100513", v); end
        peek(32'h4, v);
        checks++; if (v !== 32'h00200593) begin errors++; $display("FAIL stall_mem1: got %h, expected 00200593", v); end
        @(negedge clk);
    endtask

    task automatic test_zero_count;
        logic [31:0] v;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (cpu_rst_o !== 1'b1 || byte_ready_o !== 1'b0) begin errors++; $display("FAIL zero_idle: got cpu_rst=%b ready=%b, expected 1 0", cpu_rst_o, byte_ready_o); end
        do_start(7'd0);
        checks++; if (done_o !== 1'b1 || cpu_rst_o !== 1'b0) begin errors++; $display("FAIL zero_run: got done=%b cpu_rst=%b, expected 1 0", done_o, cpu_rst_o); end
        checks++; if (byte_ready_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL zero_flags: got ready=%b busy=%b, expected 0 0", byte_ready_o, busy_o); end
        byte_i = 8'hFF; byte_valid_i = 1'b1;
        @(negedge clk);
        byte_valid_i = 1'b0;
        checks++; if (done_o !== 1'b0 || byte_ready_o !== 1'b0) begin errors++; $display("FAIL zero_after: got done=%b ready=%b, expected 0 0", done_o, byte_ready_o); end
        peek(32'h0, v);
        checks++; if (v !== 32'h00100513) begin errors++; $display("FAIL zero_mem0: got %h, expected 00100513", v); end
        peek(32'h4, v);
        checks++; if (v !== 32'h00200593) begin errors++; $display("FAIL zero_mem1: got %h, expected 00200593", v); end
    endtask

    task automatic test_reset_mid_load;
        bit ok, all_ok;
        logic [31:0] v;
        logic [7:0] part [5] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h11};
        logic [7:0] redo [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
        all_ok = 1'b1;
        do_start(7'd2);
        for (int i = 0; i < 5; i++) begin
            send_byte(part[i], ok);
            all_ok &= ok;
        end
        checks++; if (!all_ok || words_loaded_o !== 7'd1) begin errors++; $display("FAIL rmid_partial: got ok=%b words=%0d, expected 1 1", all_ok, words_loaded_o); end
        rst = 1'b1;
        #1;
        checks++; if (cpu_rst_o !== 1'b1 || byte_ready_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL rmid_async: got cpu_rst=%b ready=%b busy=%b, expected 1 0 0", cpu_rst_o, byte_ready_o, busy_o); end
        @(negedge clk);
        rst = 1'b0;
        peek(32'h0, v);
        checks++; if (v !== 32'hDEADBEEF) begin errors++; $display("FAIL rmid_mem0: got %h, expected deadbeef", v); end
        peek(32'h4, v);
        checks++; if (v !== 32'h00200593) begin errors++; $display("FAIL rmid_mem1: got %h, expected 00200593", v); end
        all_ok = 1'b1;
        do_start(7'd1);
        for (int i = 0; i < 4; i++) begin
            send_byte(redo[i], ok);
            all_ok &= ok;
        end
        checks++; if (!all_ok || done_o !== 1'b1 || words_loaded_o !== 7'd1) begin errors++; $display("FAIL rmid_restart: got ok=%b done=%b words=%0d, expected 1 1 1", all_ok, done_o, words_loaded_o); end
        peek(32'h0, v);
        checks++; if (v !== 32'h12345678) begin errors++; $display("FAIL rmid_restart_mem0: got %h, expected 12345678", v); end
        peek(32'h4, v);
        checks++; if (v !== 32'h00200593) begin errors++; $display("FAIL rmid_restart_mem1: got %h, expected 00200593", v); end
        @(negedge clk);
    endtask

    task automatic test_clamp;
        int accepted;
        logic [31:0] v;
        accepted = 0;
        do_start(7'd100);
        for (int i = 0; i < 400; i++) begin
            byte_i       = accepted[7:0];
            byte_valid_i = 1'b1;
            if (byte_ready_o === 1'b1) accepted++;
            @(negedge clk);
        end
        byte_valid_i = 1'b0;
        checks++; if (accepted !== 256) begin errors++; $display("FAIL clamp_bytes: got %0d, expected 256", accepted); end
        checks++; if (words_loaded_o !== 7'd64) begin errors++; $display("FAIL clamp_words: got %0d, expected 64", words_loaded_o); end
        checks++; if (byte_ready_o !== 1'b0) begin errors++; $display("FAIL clamp_ready: got %b, expected 0", byte_ready_o); end
        peek(32'h0, v);
        checks++; if (v !== 32'h03020100) begin errors++; $display("FAIL clamp_mem0: got %h, expected 03020100", v); end
        peek(32'hFC, v);
        checks++; if (v !== 32'hFFFEFDFC) begin errors++; $display("FAIL clamp_mem63: got %h, expected fffefdfc", v); end
    endtask

    task automatic test_start_ignored;
        bit ok, all_ok;
        int d0;
        logic [31:0] v;
        all_ok = 1'b1;
        d0 = done_cnt;
        do_start(7'd3);
        for (int i = 0; i < 5; i++) begin
            send_byte(8'h40 + 8'(i), ok);
            all_ok &= ok;
        end
        start_i = 1'b1; word_count_i = 7'd1;
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 5; i < 12; i++) begin
            send_byte(8'h40 + 8'(i), ok);
            all_ok &= ok;
        end
        checks++; if (!all_ok || done_o !== 1'b1 || words_loaded_o !== 7'd3) begin errors++; $display("FAIL ign_done: got ok=%b done=%b words=%0d, expected 1 1 3", all_ok, done_o, words_loaded_o); end
        @(negedge clk);
        #1;
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL ign_done_count: got %0d, expected 1", done_cnt - d0); end
        peek(32'h0, v);
        checks++; if (v !== 32'h43424140) begin errors++; $display("FAIL ign_mem0: got %h, expected 43424140", v); end
        peek(32'h4, v);
        checks++; if (v !== 32'h47464544) begin errors++; $display("FAIL ign_mem1: got %h, expected 47464544", v); end
        peek(32'h8, v);
        checks++; if (v !== 32'h4B4A4948) begin errors++; $display("FAIL ign_mem2: got %h, expected 4b4a4948", v); end
        @(negedge clk);
        checks++; if (cpu_rst_o !== 1'b0) begin errors++; $display("FAIL ign_run: got cpu_rst=%b, expected 0", cpu_rst_o); end
        do_start(7'd1);
        checks++; if (cpu_rst_o !== 1'b1 || busy_o !== 1'b1 || byte_ready_o !== 1'b1) begin errors++; $display("FAIL ign_reload: got cpu_rst=%b busy=%b ready=%b, expected 1 1 1", cpu_rst_o, busy_o, byte_ready_o); end
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_stall;
        test_zero_count;
        test_reset_mid_load;
        test_clamp;
        test_start_ignored;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory that the fetch stage reads.
- Accepts a byte stream from a host link (UART or JTAG bridge) and packs it into little-endian 32-bit words.
- Writes the words at sequential word addresses into an internal instruction RAM.
- Holds the core in reset while loading. Exposes the same asynchronous word-read port the fetch stage uses today (pc in, instruction out).

Parameters:
- ADDR_W, 6, word-address width; RAM depth DEPTH = 2**ADDR_W words (default 64).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  one-cycle pulse: begin a load
- word_count_i  in  ADDR_W+1  number of words to load, sampled on start_i
- byte_i  in  8  stream data byte
- byte_valid_i  in  1  stream data valid
- byte_ready_o  out  1  loader accepts a byte this cycle
- pc_i  in  32  fetch address (byte address)
- instr_o  out  32  instruction word at pc_i
- cpu_rst_o  out  1  core reset request, active-high
- busy_o  out  1  load in progress
- done_o  out  1  one-cycle pulse when a load completes
- words_loaded_o  out  ADDR_W+1  words written in the current or last load

Behaviour:
- State machine, states IDLE, LOAD, RUN. Reset puts it in IDLE.
- Output reset values: byte_ready_o=0, cpu_rst_o=1, busy_o=0, done_o=0, words_loaded_o=0. Internal byte index=0, write address=0, assembly register=0.
- RAM contents are not reset and survive rst.
- IDLE: cpu_rst_o=1, byte_ready_o=0.
  - start_i with word_count_i>0 -> LOAD.
  - start_i with word_count_i==0 -> RUN, done_o=1 in the first RUN cycle.
- On entering LOAD (the start_i edge):
  - Latch target = min(word_count_i, DEPTH).
  - Clear byte index, write address and words_loaded_o.
- LOAD: byte_ready_o=1, busy_o=1, cpu_rst_o=1.
  - A byte is accepted on a posedge where byte_valid_i && byte_ready_o.
  - Accepted byte k (k=0..3) fills bits [8k+7:8k].
  - On the 4th byte, the word (three latched bytes plus the incoming byte) is written to mem[write address] on the same edge.
  - On that same edge: write address +1, words_loaded_o +1, byte index -> 0.
  - When the written word is number target, go to RUN on that edge. byte_ready_o is 0 from the next cycle, so no extra byte is taken.
  - byte_valid_i low stalls indefinitely with no timeout; byte index and partial word are held.
- RUN: cpu_rst_o=0, byte_ready_o=0, busy_o=0.
  - done_o=1 in the first RUN cycle only.
  - start_i -> LOAD, with cpu_rst_o reasserted in the same cycle as LOAD.
- start_i during LOAD is ignored; the load continues with the original target.
- Read port is combinational: instr_o = mem[pc_i[ADDR_W+1:2]].
  - pc_i[1:0] and pc_i[31:ADDR_W+2] are ignored, so addresses wrap modulo DEPTH.
  - A read of the address being written in the same cycle returns the old word.
- Asynchronous rst mid-load:
  - Immediately returns to IDLE; cpu_rst_o=1, byte_ready_o=0.
  - Complete words already written stay in RAM; a partial word is discarded.
- Target clamp: word_count_i > DEPTH loads exactly DEPTH words, and the address never wraps during a load.

Decomposition:
- Shared package: state encoding (IDLE/RUN/LOAD) and constant BYTES_PER_WORD=4.
- One sub-module, byte_word_packer: byte index counter, assembly register, word_valid strobe and packed word.
- The FSM, address counter and RAM stay in imem_loader.

Test Plan:
- Reset, then start_i with word_count_i=2, bytes 13 05 10 00 93 05 20 00 back-to-back.
  - Required: mem[0]=0x00100513, mem[1]=0x00200593.
  - done_o pulses one cycle after the 8th byte; cpu_rst_o falls in that same cycle.
  - instr_o=0x00200593 for pc_i=0x4 and for pc_i=0x104 (wrap).
- Same load with byte_valid_i deasserted for 3 cycles between every byte.
  - Required: identical RAM contents, words_loaded_o=2, byte_ready_o stays 1 throughout LOAD.
- start_i with word_count_i=0.
  - Required: RUN next cycle, done_o=1 for one cycle, no bytes accepted, RAM unchanged.
- Assert rst after 5 bytes of a 2-word load.
  - Required: IDLE, cpu_rst_o=1, mem[0] holds the written word, mem[1] keeps its prior value.
  - A restart load of 1 word writes mem[0] from byte index 0.
- With ADDR_W=6, start_i with word_count_i=100, then stream 400 bytes.
  - Required: exactly 256 bytes accepted, words_loaded_o=64, byte_ready_o=0 afterwards.
- start_i pulsed mid-LOAD with word_count_i=1 during a 3-word load.
  - Required: ignored; all 3 words written, done_o once.
  - A subsequent start_i in RUN reasserts cpu_rst_o in the same cycle.
